// File: rtl/exchange_scheduler.sv
// Replica-exchange round controller: alternates even/odd pairing, makes the Metropolis
// accept decision per pair, issues exchange commands, times the route transfer, arbitrates host reads.
module exchange_scheduler #(
  parameter int REPLICA_NUM = 8,
  parameter int CITY_DIV    = 8,
  parameter int PIPE_LAT    = 3,
  parameter int DW          = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [(REPLICA_NUM-1)*DW-1:0]     delta_e,
  input  logic [(REPLICA_NUM-1)*DW-1:0]     thresh,
  output logic [REPLICA_NUM*2-1:0]          ex_command,
  output logic                              busy,
  output logic                              done,
  output logic                              phase,
  output logic [REPLICA_NUM-2:0]            ex_flag,
  output logic [$clog2(REPLICA_NUM):0]      acc_count,
  output logic [31:0]                       total_acc,
  input  logic                              host_req,
  output logic                              host_gnt
);

  localparam int NPAIR = REPLICA_NUM - 1;
  localparam int ACC_W = $clog2(REPLICA_NUM) + 1;
  localparam int CNT_W = $clog2(CITY_DIV + PIPE_LAT) + 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(CITY_DIV + PIPE_LAT - 1);

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_SELF = 2'd1,
    CMD_PREV = 2'd2,
    CMD_FOLW = 2'd3
  } exchange_command_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_ISSUE,
    S_XFER,
    S_FIN
  } state_e;

  state_e                   state_q;
  logic                     pend_q;
  logic [CNT_W-1:0]         beat_q;
  logic                     phase_q;
  logic                     busy_q;
  logic                     done_q;
  logic [REPLICA_NUM*2-1:0] ex_command_q;
  logic [NPAIR-1:0]         ex_flag_q;
  logic [ACC_W-1:0]         acc_count_q;
  logic [31:0]              total_acc_q;
  logic                     host_gnt_q;

  logic [NPAIR-1:0]         accept_d;
  logic [ACC_W-1:0]         acc_cnt_d;
  logic [REPLICA_NUM-1:0]   lower_acc;
  logic [REPLICA_NUM-1:0]   upper_acc;
  logic [REPLICA_NUM*2-1:0] cmd_d;
  logic [32:0]              total_sum;
  logic [31:0]              total_acc_d;

  // Metropolis decision for the pairing of the round now in DECIDE (phase already toggled).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    accept_d    = '0;
    acc_cnt_d   = '0;
    cmd_d       = '0;
    total_acc_d = total_acc_q;
    for (int i = 0; i < NPAIR; i++) begin
      if (((i % 2) == int'(phase_q)) &&
          ($signed(delta_e[i*DW +: DW]) <= $signed(thresh[i*DW +: DW]))) begin
        accept_d[i] = 1'b1;
        acc_cnt_d   = acc_cnt_d + ACC_W'(1);
      end
    end
    // Replica r is the lower member of pair r and the upper member of pair r-1.
    lower_acc = {1'b0, accept_d};
    upper_acc = {accept_d, 1'b0};
    for (int r = 0; r < REPLICA_NUM; r++) begin
      cmd_d[r*2 +: 2] = lower_acc[r] ? CMD_FOLW : (upper_acc[r] ? CMD_PREV : CMD_SELF);
    end
    total_sum = {1'b0, total_acc_q} + {{(33-ACC_W){1'b0}}, acc_cnt_d};
    if (state_q == S_DECIDE) begin
      total_acc_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
    end
  end

  // NOTE: all state and registered outputs update with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      beat_q       <= '0;
      phase_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ex_command_q <= '0;
      ex_flag_q    <= '0;
      acc_count_q  <= '0;
      total_acc_q  <= '0;
      host_gnt_q   <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      ex_command_q <= '0;
      host_gnt_q   <= 1'b0;
      total_acc_q  <= total_acc_d;
      case (state_q)
        S_IDLE: begin
          host_gnt_q <= host_req;
          if ((start || pend_q) && !host_gnt_q && !host_req) begin
            state_q <= S_DECIDE;
            phase_q <= ~phase_q;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (start) begin
            pend_q <= 1'b1;
          end
        end
        S_DECIDE: begin
          ex_flag_q    <= accept_d;
          acc_count_q  <= acc_cnt_d;
          ex_command_q <= cmd_d;
          state_q      <= S_ISSUE;
        end
        S_ISSUE: begin
          beat_q  <= '0;
          state_q <= S_XFER;
        end
        S_XFER: begin
          if (beat_q == BEAT_LAST) begin
            beat_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            beat_q <= beat_q + CNT_W'(1);
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ex_command = ex_command_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign phase      = phase_q;
  assign ex_flag    = ex_flag_q;
  assign acc_count  = acc_count_q;
  assign total_acc  = total_acc_q;
  assign host_gnt   = host_gnt_q;

endmodule
